match_checker: RTL

- Downstream of the card memory stage. Consumes each one-cycle card-reveal pulse together with the revealed card value and its board position.
- Groups reveals into pairs and compares the symbols.
- Match: scores the pair for the current player.
- Miss: holds both cards visible for a delay, then issues a hide request back to memory and passes the turn.
- Also drives a restart pulse to the turn timer, and flags game end plus the winner.

---
 rtl/match_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/match_checker.sv
// Pairs up card reveals, compares their symbols, scores matches and schedules
// the hide request for mismatched pairs; reports game end and the winner.
module match_checker #(
  parameter int HIDE_DELAY = 50000000,
  parameter int NUM_PAIRS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       selection,
  input  logic [3:0] card,
  input  logic [1:0] card_x,
  input  logic [1:0] card_y,
  output logic       match,
  output logic       miss,
  output logic       hide_valid,
  output logic [1:0] hide_x1,
  output logic [1:0] hide_y1,
  output logic [1:0] hide_x2,
  output logic [1:0] hide_y2,
  output logic       timer_restart,
  output logic       player,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int CntW = $clog2(HIDE_DELAY) + 1;

  typedef enum logic [2:0] {FIRST, SECOND, COMPARE, DELAY, DONE} state_t;

  state_t            state;
  logic [2:0]        sym1, sym2;
  logic [1:0]        pos1X, pos1Y, pos2X, pos2Y;
  logic [CntW-1:0]   delayCnt;
  logic [3:0]        pairs;
  logic [3:0]        nextP1, nextP2;
  logic [1:0]        nextWinner;

  // The revealed flag plays no part in the comparison.
  logic unusedRevealedFlag;
  assign unusedRevealedFlag = card[3];

  // Scores as they stand after crediting the current player with a match.
  always_comb begin
    nextP1     = score_p1 + {3'b000, ~player};
    nextP2     = score_p2 + {3'b000, player};
    nextWinner = 2'b11;
    if (nextP1 > nextP2)      nextWinner = 2'b01;
    else if (nextP2 > nextP1) nextWinner = 2'b10;
  end

  // NOTE: every register is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FIRST;
      sym1          <= '0;
      sym2          <= '0;
      pos1X         <= '0;
      pos1Y         <= '0;
      pos2X         <= '0;
      pos2Y         <= '0;
      delayCnt      <= '0;
      pairs         <= '0;
      match         <= 1'b0;
      miss          <= 1'b0;
      hide_valid    <= 1'b0;
      hide_x1       <= '0;
      hide_y1       <= '0;
      hide_x2       <= '0;
      hide_y2       <= '0;
      timer_restart <= 1'b0;
      player        <= 1'b0;
      score_p1      <= '0;
      score_p2      <= '0;
      game_over     <= 1'b0;
      winner        <= '0;
    end else begin
      match         <= 1'b0;
      miss          <= 1'b0;
      hide_valid    <= 1'b0;
      timer_restart <= 1'b0;
      unique case (state)
        FIRST: begin
          if (selection) begin
            sym1  <= card[2:0];
            pos1X <= card_x;
            pos1Y <= card_y;
            state <= SECOND;
          end
        end
        SECOND: begin
          // A second press on the card already showing is not a new reveal.
          if (selection && !(card_x == pos1X && card_y == pos1Y)) begin
            sym2  <= card[2:0];
            pos2X <= card_x;
            pos2Y <= card_y;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (sym1 == sym2) begin
            match         <= 1'b1;
            timer_restart <= 1'b1;
            score_p1      <= nextP1;
            score_p2      <= nextP2;
            pairs         <= pairs + 4'd1;
            if (pairs == 4'(NUM_PAIRS - 1)) begin
              game_over <= 1'b1;
              winner    <= nextWinner;
              state     <= DONE;
            end else begin
              state <= FIRST;
            end
          end else begin
            miss     <= 1'b1;
            delayCnt <= CntW'(HIDE_DELAY - 1);
            state    <= DELAY;
          end
        end
        DELAY: begin
          if (delayCnt == '0) begin
            hide_valid    <= 1'b1;
            hide_x1       <= pos1X;
            hide_y1       <= pos1Y;
            hide_x2       <= pos2X;
            hide_y2       <= pos2Y;
            timer_restart <= 1'b1;
            player        <= ~player;
            state         <= FIRST;
          end else begin
            delayCnt <= delayCnt - 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= FIRST;
      endcase
    end
  end

endmodule
